// File: rtl/wb_stage_pipelined.sv
// Registered write-back stage: selects and formats the instruction result, holds it
// in a single output register, drives the register-file write and forwarding bus.
module wb_stage_pipelined #(
    parameter int DATA_W     = 32,
    parameter int REG_ADDR_W = 5,
    parameter int RETIRE_W   = 32
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [DATA_W-1:0]     alu_result,
    input  logic [DATA_W-1:0]     read_data,
    input  logic [DATA_W-1:0]     pc_plus4,
    input  logic [DATA_W-1:0]     imm,
    input  logic [1:0]            src_sel,
    input  logic [1:0]            ld_size,
    input  logic                  ld_unsigned,
    input  logic                  reg_write,
    input  logic [REG_ADDR_W-1:0] rd,
    input  logic                  wb_stall,
    output logic                  rf_we,
    output logic [REG_ADDR_W-1:0] rf_waddr,
    output logic [DATA_W-1:0]     rf_wdata,
    output logic                  fwd_valid,
    output logic [REG_ADDR_W-1:0] fwd_rd,
    output logic [DATA_W-1:0]     fwd_data,
    output logic                  misalign,
    output logic [RETIRE_W-1:0]   retire_count
);

    localparam int OFF_W = $clog2(DATA_W / 8);

    localparam logic [1:0] SRC_ALU = 2'd0;
    localparam logic [1:0] SRC_MEM = 2'd1;
    localparam logic [1:0] SRC_PC  = 2'd2;
    localparam logic [1:0] SRC_IMM = 2'd3;

    localparam logic [1:0] LD_BYTE  = 2'd0;
    localparam logic [1:0] LD_HALF  = 2'd1;
    localparam logic [1:0] LD_WORD  = 2'd2;
    localparam logic [1:0] LD_DWORD = 2'd3;

    localparam logic [DATA_W-1:0] ALL_ONES  = {DATA_W{1'b1}};
    localparam logic [DATA_W-1:0] MASK_BYTE = ALL_ONES >> (DATA_W - 8);
    localparam logic [DATA_W-1:0] MASK_HALF = ALL_ONES >> (DATA_W - 16);
    localparam logic [DATA_W-1:0] MASK_WORD = ALL_ONES >> (DATA_W - 32);

    // Keep the low bits selected by size and fill the rest with zero or the sign bit;
    // a full-width load has an all-ones mask, so the extension choice has no effect.
    function automatic logic [DATA_W-1:0] format_load(
        input logic [DATA_W-1:0] word,
        input logic [1:0]        size,
        input logic              zero_ext
    );
        logic [DATA_W-1:0] keep_mask;
        logic              sign_bit;
        case (size)
            LD_BYTE: begin
                keep_mask = MASK_BYTE;
                sign_bit  = word[7];
            end
            LD_HALF: begin
                keep_mask = MASK_HALF;
                sign_bit  = word[15];
            end
            LD_WORD: begin
                keep_mask = MASK_WORD;
                sign_bit  = word[31];
            end
            default: begin
                keep_mask = ALL_ONES;
                sign_bit  = word[DATA_W-1];
            end
        endcase
        if (zero_ext) begin
            format_load = word & keep_mask;
        end else begin
            format_load = (word & keep_mask) | (~keep_mask & {DATA_W{sign_bit}});
        end
    endfunction

    logic [OFF_W-1:0]      offset_s;
    logic [DATA_W-1:0]     shifted_s;
    logic [DATA_W-1:0]     result_s;
    logic                  misalign_s;
    logic                  accept_s;
    logic                  consume_s;
    logic                  entry_ok_s;

    logic                  out_valid_r;
    logic                  reg_r;
    logic [REG_ADDR_W-1:0] rd_r;
    logic [DATA_W-1:0]     data_r;
    logic                  misalign_r;
    logic [RETIRE_W-1:0]   retire_r;

    assign offset_s  = alu_result[OFF_W-1:0];
    assign shifted_s = read_data >> {offset_s, 3'b000};

    assign in_ready  = !out_valid_r || !wb_stall;
    assign accept_s  = in_valid && in_ready;
    assign consume_s = out_valid_r && !wb_stall;

    // Result source select, with load formatting on the memory path
    always_comb begin
        result_s = {DATA_W{1'b0}};
        case (src_sel)
            SRC_ALU: result_s = alu_result;
            SRC_MEM: result_s = format_load(shifted_s, ld_size, ld_unsigned);
            SRC_PC:  result_s = pc_plus4;
            SRC_IMM: result_s = imm;
            default: result_s = alu_result;
        endcase
    end

    // Alignment check on loads; a double-word load is illegal on a 32-bit datapath
    always_comb begin
        misalign_s = 1'b0;
        if (src_sel == SRC_MEM) begin
            case (ld_size)
                LD_BYTE:  misalign_s = 1'b0;
                LD_HALF:  misalign_s = offset_s[0];
                LD_WORD:  misalign_s = (offset_s[1:0] != 2'b00);
                LD_DWORD: begin
                    if (DATA_W == 32) begin
                        misalign_s = 1'b1;
                    end else begin
                        misalign_s = (offset_s != {OFF_W{1'b0}});
                    end
                end
                default:  misalign_s = 1'b1;
            endcase
        end else begin
            misalign_s = 1'b0;
        end
    end

    // Output register occupancy: load on accept, drain on consume, hold while stalled
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid_r <= 1'b0;
        end else if (accept_s) begin
            out_valid_r <= 1'b1;
        end else if (consume_s) begin
            out_valid_r <= 1'b0;
        end else begin
            out_valid_r <= out_valid_r;
        end
    end

    // Output entry payload, replaced only when a new instruction is accepted
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            reg_r      <= 1'b0;
            rd_r       <= {REG_ADDR_W{1'b0}};
            data_r     <= {DATA_W{1'b0}};
            misalign_r <= 1'b0;
        end else if (accept_s) begin
            reg_r      <= reg_write;
            rd_r       <= rd;
            data_r     <= result_s;
            misalign_r <= misalign_s;
        end else begin
            reg_r      <= reg_r;
            rd_r       <= rd_r;
            data_r     <= data_r;
            misalign_r <= misalign_r;
        end
    end

    // Retired-instruction counter; every consumed entry retires, wrapping naturally
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            retire_r <= {RETIRE_W{1'b0}};
        end else if (consume_s) begin
            retire_r <= retire_r + RETIRE_W'(1'b1);
        end else begin
            retire_r <= retire_r;
        end
    end

    // x0 writes and misaligned loads retire but never update or forward
    assign entry_ok_s   = reg_r && (rd_r != {REG_ADDR_W{1'b0}}) && !misalign_r;

    assign rf_we        = consume_s && entry_ok_s;
    assign rf_waddr     = rd_r;
    assign rf_wdata     = data_r;
    assign fwd_valid    = out_valid_r && entry_ok_s;
    assign fwd_rd       = rd_r;
    assign fwd_data     = data_r;
    assign misalign     = misalign_r;
    assign retire_count = retire_r;

endmodule

// File: tb/tb_wb_stage_pipelined.sv
// Scoreboard bench for wb_stage_pipelined: directed vectors push hand-computed
// expectations; a monitor tracks occupancy and checks the outputs every cycle.
module tb_wb_stage_pipelined;

    logic        clk;
    logic        rst_n;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] alu_result;
    logic [31:0] read_data;
    logic [31:0] pc_plus4;
    logic [31:0] imm;
    logic [1:0]  src_sel;
    logic [1:0]  ld_size;
    logic        ld_unsigned;
    logic        reg_write;
    logic [4:0]  rd;
    logic        wb_stall;
    logic        rf_we;
    logic [4:0]  rf_waddr;
    logic [31:0] rf_wdata;
    logic        fwd_valid;
    logic [4:0]  fwd_rd;
    logic [31:0] fwd_data;
    logic        misalign;
    logic [3:0]  retire_count;

    wb_stage_pipelined #(
        .DATA_W(32),
        .REG_ADDR_W(5),
        .RETIRE_W(4)
    ) dut (
        .clk(clk),
        .rst_n(rst_n),
        .in_valid(in_valid),
        .in_ready(in_ready),
        .alu_result(alu_result),
        .read_data(read_data),
        .pc_plus4(pc_plus4),
        .imm(imm),
        .src_sel(src_sel),
        .ld_size(ld_size),
        .ld_unsigned(ld_unsigned),
        .reg_write(reg_write),
        .rd(rd),
        .wb_stall(wb_stall),
        .rf_we(rf_we),
        .rf_waddr(rf_waddr),
        .rf_wdata(rf_wdata),
        .fwd_valid(fwd_valid),
        .fwd_rd(fwd_rd),
        .fwd_data(fwd_data),
        .misalign(misalign),
        .retire_count(retire_count)
    );

    typedef struct packed {
        logic        we;
        logic        mis;
        logic [4:0]  rd;
        logic [31:0] data;
    } exp_t;

    exp_t sbq[$];
    int   tests = 0;
    int   fails = 0;
    bit   occ = 1'b0;
    logic [3:0] ret_model = 4'd0;
    int   we_total = 0;
    int   cyc = 0;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    // Occupancy model and scoreboard pops at the active edge
    always @(posedge clk or negedge rst_n) begin
        bit cons;
        bit acc;
        if (!rst_n) begin
            occ = 1'b0;
            sbq.delete();
            ret_model = 4'd0;
        end else begin
            cyc++;
            if (rf_we === 1'b1) we_total++;
            cons = occ && !wb_stall;
            acc  = in_valid && (!occ || !wb_stall);
            if (cons) begin
                if (sbq.size() > 0) sbq.delete(0);
                ret_model = ret_model + 4'd1;
            end
            if (acc) occ = 1'b1;
            else if (cons) occ = 1'b0;
        end
    end

    // Output checks on the falling edge, away from register updates
    always @(negedge clk) begin
        exp_t h;
        if (rst_n) begin
            chk("in_ready", 64'(in_ready), 64'(!occ || !wb_stall));
            chk("retire_count", 64'(retire_count), 64'(ret_model));
            if (occ) begin
                if (sbq.size() == 0) begin
                    tests++;
                    fails++;
                    $display("FAIL sb_empty: got entry held expected none queued");
                end else begin
                    h = sbq[0];
                    chk("rf_we", 64'(rf_we), 64'(h.we && !wb_stall));
                    chk("fwd_valid", 64'(fwd_valid), 64'(h.we));
                    chk("misalign", 64'(misalign), 64'(h.mis));
                    chk("rf_waddr", 64'(rf_waddr), 64'(h.rd));
                    chk("fwd_rd", 64'(fwd_rd), 64'(h.rd));
                    chk("rf_wdata", 64'(rf_wdata), 64'(h.data));
                    chk("fwd_data", 64'(fwd_data), 64'(h.data));
                end
            end else begin
                chk("idle_rf_we", 64'(rf_we), 64'd0);
                chk("idle_fwd_valid", 64'(fwd_valid), 64'd0);
            end
        end
    end

    // Called one time unit after a rising edge; returns at the same phase after acceptance
    task automatic send(input logic [1:0] s, input logic [31:0] a, input logic [31:0] mem,
                        input logic [31:0] pc, input logic [31:0] im, input logic [1:0] sz,
                        input logic u, input logic rw, input logic [4:0] r,
                        input logic [31:0] ed, input logic ew, input logic em);
        bit   acc;
        int   tries;
        exp_t e;
        src_sel     = s;
        alu_result  = a;
        read_data   = mem;
        pc_plus4    = pc;
        imm         = im;
        ld_size     = sz;
        ld_unsigned = u;
        reg_write   = rw;
        rd          = r;
        in_valid    = 1'b1;
        acc   = 1'b0;
        tries = 0;
        while (!acc && tries < 50) begin
            #1;
            acc = in_ready;
            @(posedge clk);
            #1;
            tries++;
        end
        in_valid = 1'b0;
        if (acc) begin
            e.we   = ew;
            e.mis  = em;
            e.rd   = r;
            e.data = ed;
            sbq.push_back(e);
        end else begin
            tests++;
            fails++;
            $display("FAIL accept_timeout: got no accept in %0d cycles expected accept", tries);
        end
    endtask

    task automatic idle(input int n);
        in_valid = 1'b0;
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got no finish expected finish before 100000");
        $fatal(1, "watchdog");
    end

    initial begin
        int w0;
        int c0;
        rst_n       = 1'b0;
        in_valid    = 1'b0;
        alu_result  = 32'd0;
        read_data   = 32'd0;
        pc_plus4    = 32'd0;
        imm         = 32'd0;
        src_sel     = 2'd0;
        ld_size     = 2'd0;
        ld_unsigned = 1'b0;
        reg_write   = 1'b0;
        rd          = 5'd0;
        wb_stall    = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        #1;
        chk("reset_in_ready", 64'(in_ready), 64'd1);
        chk("reset_rf_we", 64'(rf_we), 64'd0);
        chk("reset_fwd_valid", 64'(fwd_valid), 64'd0);
        chk("reset_misalign", 64'(misalign), 64'd0);
        chk("reset_rf_wdata", 64'(rf_wdata), 64'd0);
        chk("reset_retire", 64'(retire_count), 64'd0);
        @(posedge clk);
        #1;

        // ALU result, one beat
        send(2'd0, 32'h0000_1234, 32'hCAFE_F00D, 32'h44, 32'h88, 2'd0, 1'b0, 1'b1, 5'd5,
             32'h0000_1234, 1'b1, 1'b0);
        idle(1);
        chk("first_retire", 64'(retire_count), 64'd1);

        // Loads from 0x80FF_7F01
        send(2'd1, 32'h3,    32'h80FF_7F01, 32'h0, 32'h0, 2'd0, 1'b0, 1'b1, 5'd6,  32'hFFFF_FF80, 1'b1, 1'b0);
        send(2'd1, 32'h3,    32'h80FF_7F01, 32'h0, 32'h0, 2'd0, 1'b1, 1'b1, 5'd6,  32'h0000_0080, 1'b1, 1'b0);
        send(2'd1, 32'h2,    32'h80FF_7F01, 32'h0, 32'h0, 2'd1, 1'b0, 1'b1, 5'd10, 32'hFFFF_80FF, 1'b1, 1'b0);
        send(2'd1, 32'h1001, 32'h80FF_7F01, 32'h0, 32'h0, 2'd1, 1'b0, 1'b1, 5'd11, 32'hFFFF_FF7F, 1'b0, 1'b1);
        send(2'd1, 32'h2000, 32'h80FF_7F01, 32'h0, 32'h0, 2'd2, 1'b0, 1'b1, 5'd12, 32'h80FF_7F01, 1'b1, 1'b0);
        send(2'd1, 32'h2002, 32'h80FF_7F01, 32'h0, 32'h0, 2'd2, 1'b1, 1'b1, 5'd13, 32'h0000_80FF, 1'b0, 1'b1);
        send(2'd1, 32'h2000, 32'h80FF_7F01, 32'h0, 32'h0, 2'd3, 1'b0, 1'b1, 5'd14, 32'h80FF_7F01, 1'b0, 1'b1);
        send(2'd1, 32'h0,    32'h80FF_7F01, 32'h0, 32'h0, 2'd1, 1'b1, 1'b1, 5'd15, 32'h0000_7F01, 1'b1, 1'b0);

        // PC+4 to x0, IMM without reg_write, IMM with reg_write
        send(2'd2, 32'h55, 32'h66, 32'h0000_0100, 32'h999, 2'd0, 1'b0, 1'b1, 5'd0, 32'h0000_0100, 1'b0, 1'b0);
        send(2'd3, 32'h55, 32'h66, 32'h0000_0200, 32'hABCD_E000, 2'd0, 1'b0, 1'b0, 5'd9, 32'hABCD_E000, 1'b0, 1'b0);
        send(2'd3, 32'h55, 32'h66, 32'h0000_0200, 32'h0001_2000, 2'd0, 1'b0, 1'b1, 5'd17, 32'h0001_2000, 1'b1, 1'b0);
        idle(2);

        // Stall three cycles with the next beat waiting
        send(2'd0, 32'hDEAD_BEEF, 32'h0, 32'h0, 32'h0, 2'd0, 1'b0, 1'b1, 5'd7, 32'hDEAD_BEEF, 1'b1, 1'b0);
        wb_stall = 1'b1;
        w0 = we_total;
        c0 = cyc;
        fork
            send(2'd3, 32'h0, 32'h0, 32'h0, 32'h1234_5000, 2'd0, 1'b0, 1'b1, 5'd8, 32'h1234_5000, 1'b1, 1'b0);
            begin
                repeat (3) @(posedge clk);
                #1;
                wb_stall = 1'b0;
            end
        join
        chk("stall_one_write", 64'(we_total - w0), 64'd1);
        chk("stall_accept_cycle", 64'(cyc - c0), 64'd4);
        idle(2);

        // Four back-to-back beats
        w0 = we_total;
        c0 = cyc;
        for (int i = 0; i < 4; i++) begin
            send(2'd0, 32'hA000 + 32'(i), 32'h0, 32'h0, 32'h0, 2'd0, 1'b0, 1'b1, 5'd20 + 5'(i),
                 32'hA000 + 32'(i), 1'b1, 1'b0);
        end
        idle(1);
        chk("b2b_writes", 64'(we_total - w0), 64'd4);
        chk("b2b_cycles", 64'(cyc - c0), 64'd5);
        idle(1);

        // Asynchronous reset while an entry is stalled
        send(2'd0, 32'h0000_0055, 32'h0, 32'h0, 32'h0, 2'd0, 1'b0, 1'b1, 5'd3, 32'h0000_0055, 1'b1, 1'b0);
        wb_stall = 1'b1;
        @(posedge clk);
        #2;
        chk("pre_reset_fwd_valid", 64'(fwd_valid), 64'd1);
        chk("pre_reset_retire", 64'(retire_count), 64'd2);
        rst_n = 1'b0;
        #1;
        chk("async_rst_rf_we", 64'(rf_we), 64'd0);
        chk("async_rst_fwd_valid", 64'(fwd_valid), 64'd0);
        chk("async_rst_retire", 64'(retire_count), 64'd0);
        chk("async_rst_in_ready", 64'(in_ready), 64'd1);
        wb_stall = 1'b0;
        #2;
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        // Seventeen consumes on a 4-bit counter wrap to one
        for (int i = 0; i < 17; i++) begin
            send(2'd0, 32'(i), 32'h0, 32'h0, 32'h0, 2'd0, 1'b0, 1'b1, 5'd1 + 5'(i % 16),
                 32'(i), 1'b1, 1'b0);
        end
        idle(2);
        chk("retire_wrap", 64'(retire_count), 64'd1);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
